// File: rtl/mem_pkg.sv
// Shared types and constants for the paged memory controller.
// Optional parity support is enabled by defining MEM_PARITY_EN.
package mem_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Page assignment used by the matrix ALU sequencer (page 0 is reserved).
  localparam int PAGE_OPCODE = 1;
  localparam int PAGE_MATRIX = 2;
  localparam int PAGE_RESULT = 3;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;

  // Even-parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// PAGES x DEPTH storage array: synchronous write port, synchronous read port
// with one-cycle latency. The array itself is never reset.
// With MEM_PARITY_EN defined, an even-parity bit is stored per word and a
// mismatch flag is returned alongside each read word.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int PAGES  = 4,
  parameter int DEPTH  = 16,
  parameter int PAGE_W = 2,
  parameter int ROW_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [PAGE_W-1:0] i_page,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_par_err
);

  localparam int N  = PAGES * DEPTH;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] r_mem [N];
  logic [DATA_W-1:0] r_rdata;

  assign w_idx   = AW'(int'(i_page) * DEPTH + int'(i_row));
  assign o_rdata = r_rdata;

  // Write port: storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[w_idx] <= i_wdata;
  end

  // Read port: registered output, cleared on reset so rdata starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[w_idx];
  end

`ifdef MEM_PARITY_EN
  logic r_par [N];
  logic r_par_bad;

  // Parity bit written alongside each data word.
  always_ff @(posedge clk) begin
    if (i_we) r_par[w_idx] <= even_parity(PAR_MAX_W'(i_wdata));
  end

  // Mismatch flag registered in step with r_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_par_bad <= 1'b0;
    else if (i_re) r_par_bad <= even_parity(PAR_MAX_W'(r_mem[w_idx])) ^ r_par[w_idx];
  end

  assign o_par_err = r_par_bad;
`else
  assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/paged_mem_ctrl.sv
// Paged memory controller: one request starts a read or write burst of len+1
// beats over consecutive rows of one page, wrapping within the page.
// Requests to a page >= PAGES complete immediately with err.
// Optional parity checking is enabled by defining MEM_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for req; busy=0
// RD      | one row read issued per cycle; data appears one cycle later
// WR      | wready=1; wdata written to current row each cycle
// FIN     | done pulse (err if page range or parity error); last read beat may be valid
module paged_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int PAGES  = 4,
  parameter int DEPTH  = 16,
  parameter int PAGE_W = 2,
  parameter int ROW_W  = 4,
  parameter int LEN_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [PAGE_W+ROW_W-1:0] addr,
  input  logic [LEN_W-1:0]        len,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    wready,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  state_e             r_state;
  logic [PAGE_W-1:0]  r_page;
  logic [ROW_W-1:0]   r_row;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_par_err;
  logic               r_rvalid;

  logic [PAGE_W-1:0]  w_req_page;
  logic               w_page_bad;
  logic [ROW_W-1:0]   w_row_next;
  logic               w_par_bad;

  assign w_req_page = addr[PAGE_W+ROW_W-1 -: PAGE_W];
  assign w_page_bad = int'(w_req_page) >= PAGES;
  assign w_row_next = (r_row == ROW_W'(DEPTH - 1)) ? '0 : r_row + ROW_W'(1);

  // FSM, row counter and remaining-beat down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_page    <= '0;
      r_row     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_par_err <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= (r_state == ST_RD);
      if (r_rvalid && w_par_bad) r_par_err <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_page    <= w_req_page;
            r_row     <= addr[ROW_W-1:0];
            r_cnt     <= len;
            r_par_err <= 1'b0;
            if (w_page_bad) begin
              r_err   <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_err   <= 1'b0;
              r_state <= we ? ST_WR : ST_RD;
            end
          end
        end
        ST_RD, ST_WR: begin
          r_row <= w_row_next;
          if (r_cnt == '0) r_state <= ST_FIN;
          else             r_cnt   <= r_cnt - LEN_W'(1);
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mem_bank #(
    .DATA_W (DATA_W),
    .PAGES  (PAGES),
    .DEPTH  (DEPTH),
    .PAGE_W (PAGE_W),
    .ROW_W  (ROW_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (r_state == ST_WR),
    .i_re      (r_state == ST_RD),
    .i_page    (r_page),
    .i_row     (r_row),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_par_err (w_par_bad)
  );

  // The final read beat lands in FIN, so its parity result is folded in directly.
  assign busy   = (r_state != ST_IDLE);
  assign wready = (r_state == ST_WR);
  assign done   = (r_state == ST_FIN);
  assign err    = (r_state == ST_FIN) & (r_err | r_par_err | (r_rvalid & w_par_bad));
  assign rvalid = r_rvalid;

endmodule

// File: doc/paged_mem_ctrl.md
# paged_mem_ctrl

Parametrised, single-clock paged memory for the matrix ALU: the opcode, matrix and result pages sit behind one request/done handshake. It replaces the tristate bus with separate read and write data paths and adds burst transfers with in-page address wrap. It also adds page-range error reporting and an optional parity check. The sequencer issues one request per burst; the storage array is never cleared by reset.

## Interface
- DATA_W, 256, word width in bits
- PAGES, 4, number of pages (page 0 reserved, 1 opcode, 2 matrix, 3 result)
- DEPTH, 16, words per page
- PAGE_W, 2, page-index field width; PAGES <= 2**PAGE_W
- ROW_W, 4, row field width; DEPTH <= 2**ROW_W
- LEN_W, 4, burst-length field width (beats = len+1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request; sampled only while busy=0
- we  in  1  1=write burst, 0=read burst; sampled with req
- addr  in  PAGE_W+ROW_W  {page, row} start address; sampled with req
- len  in  LEN_W  beats minus one; sampled with req
- wdata  in  DATA_W  write word, consumed on each clk edge with wready=1
- wready  out  1  write beat accepted this cycle
- rdata  out  DATA_W  read word, qualified by rvalid
- rvalid  out  1  read beat valid
- busy  out  1  request in progress
- done  out  1  one-cycle end-of-burst pulse
- err  out  1  one-cycle error pulse, coincident with done

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: busy=0. If req=1, latch we/addr/len, set busy=1, and go to RD or WR. If the page is >= PAGES, go directly to FIN with the error flag set; memory is not accessed.
- RD: issue one row read per cycle for len+1 cycles, then go to FIN. The array read is synchronous, so rvalid/rdata lag each issue by one cycle.
- WR: wready=1 for len+1 cycles; each cycle writes wdata to the current row. Go to FIN after the last beat.
- Row advance: row+1, wrapping to 0 after DEPTH-1 within the same page; the page never changes inside a burst.
- FIN: done=1 for one cycle, and err=1 if flagged. The last read beat may be valid in the same cycle. Go to IDLE; busy deasserts on the IDLE cycle.
- req while busy=1 is ignored; no queueing.
- Reset: all outputs 0 and state IDLE. A burst in progress is aborted; words already written stay written. Array contents are undefined after power-up and unchanged by reset.

## Timing
- Request accepted on edge T0 (IDLE, req=1); RD/WR is active from T0 to T1.
- Read: first rvalid in cycle T1–T2; beat k in cycle T1+k to T2+k. done coincides with the last beat; busy falls one cycle later.
- Write: wready during cycles T0 through T0+len. Beat k is written on edge T1+k. done is asserted in the cycle after the last beat.
- Error request: done=err=1 in cycle T0–T1. No rvalid or wready is generated.
- Minimum spacing between bursts: one IDLE cycle.

## Configuration
- MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On read, a mismatch on any beat sets a sticky error that is reported as err=1 with done at FIN.
  - Data is still returned.
- MEM_PARITY_EN undefined: no parity storage or logic; err reports page-range errors only.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, RD, WR, FIN);
  - page constants PAGE_OPCODE=1, PAGE_MATRIX=2, PAGE_RESULT=3;
  - a parity helper function.
- Sub-module mem_bank: a PAGES×DEPTH array with a synchronous write port and a synchronous read port (one-cycle read latency), plus the parity bit under MEM_PARITY_EN. The FSM, row counter and beat counter live in paged_mem_ctrl.

## Test plan
- Single write then read: write 0xA5…A5 to addr {2,3} with len=0, then read the same address. Expect rvalid one cycle after the RD state and rdata=0xA5…A5; done pulses once per burst.
- Burst wrap: write 4 beats (values 1,2,3,4) from {1,14}, then read 4 beats from {1,14}. Expect 1,2,3,4 from rows 14,15,0,1, with page 1 unchanged elsewhere.
- Page error: req with page=3 when PAGES=3. Expect done=err=1 one cycle after acceptance, no wready or rvalid, and memory unchanged.
- Busy ignore: assert req with a different addr during a 4-beat read. Expect it ignored and only one done pulse.
- Reset mid-burst: drop rst_n after 2 of 4 write beats. Expect all outputs 0 immediately and, after reset, rows 0–1 hold the new data while rows 2–3 keep their old data.
- MEM_PARITY_EN: force-flip one stored bit in mem_bank, then read 3 beats. Expect data returned and err=1 with done.
